// File: rtl/wishbone_line_memory_if.sv
// -----------------------------------------------------------------------------
// wishbone
//
// Line-granular Wishbone bundle shared by the cache hierarchy and its
// physical-memory endpoint. One transfer moves a whole 256-bit line.
//
// Port:
//   CLK    : bus clock. Every agent on the bundle runs on this clock.
//
// Signals:
//   ADR    : line address, driven by the master.
//   DAT_M  : 256-bit write data, driven by the master.
//   DAT_S  : 256-bit read data, driven by the slave.
//   SEL    : 32 byte enables, one per byte of DAT_M.
//   CYC    : bus cycle in progress, driven by the master.
//   STB    : transfer strobe, driven by the master.
//   WE     : 1 = write, 0 = read, driven by the master.
//   ACK    : normal termination, driven by the slave.
//   RTY    : retry termination, driven by the slave.
//
// Modports: master, slave.
// -----------------------------------------------------------------------------
interface wishbone (
  input logic CLK
);
  logic [31:0]  ADR;
  logic [255:0] DAT_M;
  logic [255:0] DAT_S;
  logic [31:0]  SEL;
  logic         CYC;
  logic         STB;
  logic         WE;
  logic         ACK;
  logic         RTY;

  modport master (
    input  CLK,
    input  DAT_S,
    input  ACK,
    input  RTY,
    output ADR,
    output DAT_M,
    output SEL,
    output CYC,
    output STB,
    output WE
  );

  modport slave (
    input  CLK,
    input  ADR,
    input  DAT_M,
    input  SEL,
    input  CYC,
    input  STB,
    input  WE,
    output DAT_S,
    output ACK,
    output RTY
  );
endinterface

// File: rtl/wishbone_line_memory.sv
// -----------------------------------------------------------------------------
// wishbone_line_memory
//
// Physical-memory model behind the cache hierarchy. It accepts one 256-bit
// line read or byte-masked line write at a time from a Wishbone master and
// answers with a single-cycle ACK exactly LATENCY cycles after acceptance.
// Addresses with any bit set above the index field are answered with RTY and
// touch nothing. After every response there is one RELEASE cycle in which no
// request is accepted, giving a throughput of one request per LATENCY+2
// cycles.
//
// Parameters:
//   DEPTH    : number of 256-bit lines (power of two, >= 2).
//   LATENCY  : cycles from acceptance to response (1..255).
//
// Ports:
//   clk             : system clock, same clock as memory_wishbone.CLK.
//   rst             : synchronous, active-high reset. Clears the control
//                     state, ACK/RTY, DAT_S and protocol_error; memory
//                     contents are kept.
//   memory_wishbone : wishbone.slave line port (ADR, DAT_M, SEL, CYC, STB,
//                     WE in; DAT_S, ACK, RTY out).
//   protocol_error  : sticky flag for master protocol violations.
//
// Optional feature:
//   WB_LINE_MEMORY_PROTOCOL_CHECK_EN - when defined, protocol_error is set
//   (and held until rst) if STB is high while CYC is low, or if the master
//   keeps CYC & STB high during BUSY but changes ADR, WE, SEL or DAT_M from
//   the accepted values. When undefined, protocol_error is tied low and no
//   check logic exists.
// -----------------------------------------------------------------------------
module wishbone_line_memory #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic   clk,
  input  logic   rst,
  wishbone.slave memory_wishbone,
  output logic   protocol_error
);

  localparam int ADR_W  = 32;
  localparam int LINE_W = 256;
  localparam int SEL_W  = LINE_W / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;
  logic               ack_reg;
  logic               ack_next;
  logic               rty_reg;
  logic               rty_next;

  // Request fields captured at acceptance; the response never looks at the
  // live bus again, so the master may drop or change it during BUSY.
  logic [ADR_W-1:0]   adr_reg;
  logic               we_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic [LINE_W-1:0]  dat_reg;

  logic               capture_en;
  logic               resp_en;
  logic               rd_en;
  logic               wr_en;
  logic               in_range;
  logic [IDX_W-1:0]   index;
  logic [SEL_W-1:0]   lane_we;

  logic [LINE_W-1:0]  dat_s_reg;
  logic [LINE_W-1:0]  mem [DEPTH];

  logic               req_valid;

  assign req_valid = memory_wishbone.CYC && memory_wishbone.STB;

  assign index    = adr_reg[IDX_W-1:0];
  // In range only when nothing is set above the index field.
  assign in_range = ((adr_reg >> IDX_W) == '0);

  // ---------------------------------------------------------------------------
  // FSM next-state / response decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ack_next   = 1'b0;
    rty_next   = 1'b0;
    capture_en = 1'b0;
    resp_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          capture_en = 1'b1;
          // Counting down LATENCY-1 in BUSY puts the response edge at
          // acceptance + LATENCY.
          count_next = CNT_W'(LATENCY - 1);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (count_reg != '0) begin
          count_next = count_reg - CNT_W'(1);
        end else begin
          resp_en    = 1'b1;
          ack_next   = in_range;
          rty_next   = !in_range;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        // The response pulse is visible during this cycle; the master is
        // still dropping its strobe, so nothing is accepted here.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A reset arriving on the response edge must not let the write land.
  assign rd_en = resp_en && in_range && !we_reg;
  assign wr_en = resp_en && in_range && we_reg && !rst;

  // ---------------------------------------------------------------------------
  // FSM state and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      ack_reg   <= 1'b0;
      rty_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ack_reg   <= ack_next;
      rty_reg   <= rty_next;
    end
  end

  // Request capture needs no reset: the fields are only consumed after a
  // fresh acceptance has overwritten them.
  always_ff @(posedge clk) begin
    if (capture_en) begin
      adr_reg <= memory_wishbone.ADR;
      we_reg  <= memory_wishbone.WE;
      sel_reg <= memory_wishbone.SEL;
      dat_reg <= memory_wishbone.DAT_M;
    end
  end

  // ---------------------------------------------------------------------------
  // Line storage: byte-lane write enables, synchronous write, registered read
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < SEL_W; gi++) begin : g_lane_we
    assign lane_we[gi] = wr_en && sel_reg[gi];
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < SEL_W; b++) begin
      if (lane_we[b]) begin
        mem[index][b*8 +: 8] <= dat_reg[b*8 +: 8];
      end
    end
  end

  // DAT_S only changes on an in-range read response and otherwise holds the
  // last line read, including across writes and retries.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_s_reg <= '0;
    end else if (rd_en) begin
      dat_s_reg <= mem[index];
    end
  end

  assign memory_wishbone.ACK   = ack_reg;
  assign memory_wishbone.RTY   = rty_reg;
  assign memory_wishbone.DAT_S = dat_s_reg;

  // ---------------------------------------------------------------------------
  // Optional master protocol checker
  // ---------------------------------------------------------------------------
`ifdef WB_LINE_MEMORY_PROTOCOL_CHECK_EN
  logic protocol_error_reg;
  logic violation;

  always_comb begin
    violation = 1'b0;
    if (memory_wishbone.STB && !memory_wishbone.CYC) begin
      violation = 1'b1;
    end
    if ((state_reg == BUSY) && req_valid) begin
      if ((memory_wishbone.ADR   != adr_reg) ||
          (memory_wishbone.WE    != we_reg)  ||
          (memory_wishbone.SEL   != sel_reg) ||
          (memory_wishbone.DAT_M != dat_reg)) begin
        violation = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_error_reg <= 1'b0;
    end else if (violation) begin
      protocol_error_reg <= 1'b1;
    end
  end

  assign protocol_error = protocol_error_reg;
`else
  assign protocol_error = 1'b0;
`endif

endmodule
